// File: rtl/fetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | fetch_stage: RV32I instruction fetch, single outstanding imem request,   |
// | registered IF/ID bundle with stall, redirect and a one-entry hold buffer.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [1:0]  id_immsrc
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic        drop_q, drop_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [1:0]  id_immsrc_q, id_immsrc_d;

  logic        accepted;
  logic        load_id;
  logic [31:0] load_instr;
  logic [31:0] load_pc;

  function automatic logic [1:0] immsrc_of(input logic [31:0] instr);
    case (instr[6:0])
      7'b0100011: immsrc_of = 2'b01;
      7'b1100011: immsrc_of = 2'b10;
      7'b1101111: immsrc_of = 2'b11;
      default:    immsrc_of = 2'b00;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_d       = drop_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load_id      = 1'b0;
    load_instr   = hold_instr_q;
    load_pc      = hold_pc_q;
    accepted     = req_valid_q & imem_req_ready;

    if (flush) begin
      pc_d         = flush_target & ~32'd3;
      hold_instr_d = NOP_INSTR;
      hold_pc_d    = 32'd0;
      case (state_q)
        S_REQ: begin
          // An accepted request still owes us a response that must be discarded.
          if (accepted) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        default: state_d = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (accepted) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = S_REQ;
            end else if (stall) begin
              hold_instr_d = imem_rdata;
              hold_pc_d    = pc_q;
              state_d      = S_HOLD;
            end else begin
              load_id    = 1'b1;
              load_instr = imem_rdata;
              load_pc    = pc_q;
              pc_d       = pc_q + 32'd4;
              state_d    = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            load_id = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end

    req_valid_d = (state_d == S_REQ);

    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_immsrc_d   = id_immsrc_q;
    if (flush) begin
      id_valid_d  = 1'b0;
      id_instr_d  = NOP_INSTR;
      id_immsrc_d = 2'b00;
    end else if (!stall) begin
      if (load_id) begin
        id_valid_d    = 1'b1;
        id_instr_d    = load_instr;
        id_pc_d       = load_pc;
        id_pc_plus4_d = load_pc + 32'd4;
        id_immsrc_d   = immsrc_of(load_instr);
      end else begin
        id_valid_d  = 1'b0;
        id_instr_d  = NOP_INSTR;
        id_immsrc_d = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_REQ;
      pc_q          <= RESET_PC;
      req_valid_q   <= 1'b0;
      drop_q        <= 1'b0;
      hold_instr_q  <= NOP_INSTR;
      hold_pc_q     <= 32'd0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd0;
      id_immsrc_q   <= 2'b00;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_valid_q   <= req_valid_d;
      drop_q        <= drop_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_immsrc_q   <= id_immsrc_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign id_valid       = id_valid_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc_plus4_q;
  assign id_immsrc      = id_immsrc_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_fetch_stage: bench for fetch_stage with a latency-variable memory.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall, flush;
  logic [31:0] flush_target;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic [1:0]  id_immsrc;

  logic        w_req_valid, w_req_ready, w_rsp_valid;
  logic [31:0] w_addr, w_rdata;
  logic        w_id_valid;
  logic [31:0] w_id_instr, w_id_pc, w_id_pc_plus4;
  logic [1:0]  w_id_immsrc;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rdata(imem_rdata),
    .stall(stall), .flush(flush), .flush_target(flush_target),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_immsrc(id_immsrc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_addr(w_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rdata(w_rdata),
    .stall(1'b0), .flush(1'b0), .flush_target(32'd0),
    .id_valid(w_id_valid), .id_instr(w_id_instr), .id_pc(w_id_pc),
    .id_pc_plus4(w_id_pc_plus4), .id_immsrc(w_id_immsrc)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_tab [logic [31:0]];

  // memory side
  bit          pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          lat_min = 1, lat_max = 1;

  // reference model: next PC to be delivered and the last visible bundle
  logic [31:0] model_pc;
  int          delivered;
  bit          prev_wait;
  logic [31:0] prev_addr;
  logic        s_valid;
  logic [31:0] s_instr, s_pc, s_p4;
  logic [1:0]  s_imm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (mem_tab.exists(a)) return mem_tab[a];
    h = (a ^ 32'h5bd1_e995) * 32'h9e37_79b1;
    case (h[9:7])
      3'd0:    op = 7'h03;
      3'd1:    op = 7'h13;
      3'd2:    op = 7'h23;
      3'd3:    op = 7'h63;
      3'd4:    op = 7'h67;
      3'd5:    op = 7'h6f;
      3'd6:    op = 7'h33;
      default: op = 7'h37;
    endcase
    return {h[31:7], op};
  endfunction

  function automatic logic [1:0] exp_imm(input logic [31:0] w);
    case (w[6:0])
      7'b0100011: return 2'b01;
      7'b1100011: return 2'b10;
      7'b1101111: return 2'b11;
      default:    return 2'b00;
    endcase
  endfunction

  task automatic snap();
    s_valid = id_valid; s_instr = id_instr; s_pc = id_pc; s_p4 = id_pc_plus4; s_imm = id_immsrc;
  endtask

  // One clock: drive inputs at a negedge, let the posedge happen, check at the next negedge.
  task automatic cycle(input bit st, input bit fl, input logic [31:0] tgt, input bit rdy);
    if (prev_wait) begin
      chk("req_held", {31'd0, imem_req_valid}, 32'd1);
      chk("req_addr_stable", imem_addr, prev_addr);
    end
    if (imem_req_valid) chk("req_addr", imem_addr, model_pc);
    stall = st; flush = fl; flush_target = tgt; imem_req_ready = rdy;
    imem_rsp_valid = 1'b0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt <= 0) begin
        imem_rsp_valid = 1'b1;
        imem_rdata = mem_word(pend_addr);
        pend = 1'b0;
      end
    end
    if (imem_req_valid && rdy) begin
      chk("single_outstanding", {31'd0, pend}, 32'd0);
      pend = 1'b1;
      pend_cnt = $urandom_range(lat_min, lat_max);
      pend_addr = imem_addr;
    end
    prev_wait = imem_req_valid && !rdy && !fl;
    prev_addr = imem_addr;
    @(negedge clk);
    if (fl) begin
      chk("flush_valid", {31'd0, id_valid}, 32'd0);
      chk("flush_instr", id_instr, NOP);
      model_pc = tgt & ~32'd3;
    end else if (st) begin
      chk("stall_valid", {31'd0, id_valid}, {31'd0, s_valid});
      chk("stall_instr", id_instr, s_instr);
      chk("stall_pc", id_pc, s_pc);
      chk("stall_p4", id_pc_plus4, s_p4);
      chk("stall_imm", {30'd0, id_immsrc}, {30'd0, s_imm});
    end else if (id_valid) begin
      chk("bundle_pc", id_pc, model_pc);
      chk("bundle_instr", id_instr, mem_word(model_pc));
      chk("bundle_p4", id_pc_plus4, model_pc + 32'd4);
      chk("bundle_imm", {30'd0, id_immsrc}, {30'd0, exp_imm(mem_word(model_pc))});
      model_pc = model_pc + 32'd4;
      delivered++;
    end else begin
      chk("bubble_instr", id_instr, NOP);
      chk("bubble_imm", {30'd0, id_immsrc}, 32'd0);
    end
    snap();
  endtask

  task automatic wait_bundle(input int max, input string name, output int n);
    n = 0;
    do begin
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      n++;
    end while (!id_valid && n < max);
    chk({name, "_timeout"}, {31'd0, id_valid}, 32'd1);
  endtask

  task automatic check_reset_vals(input string name);
    chk({name, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({name, "_id_valid"}, {31'd0, id_valid}, 32'd0);
    chk({name, "_id_instr"}, id_instr, NOP);
    chk({name, "_id_pc"}, id_pc, 32'd0);
    chk({name, "_id_p4"}, id_pc_plus4, 32'd0);
    chk({name, "_id_imm"}, {30'd0, id_immsrc}, 32'd0);
  endtask

  task automatic model_reset();
    pend = 1'b0; prev_wait = 1'b0; model_pc = 32'd0;
    stall = 1'b0; flush = 1'b0; flush_target = 32'd0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = 32'd0;
    w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rdata = 32'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    snap();
  endtask

  task automatic wrap_test();
    bit          acc;
    logic [31:0] acc_addr;
    logic [31:0] reqs[$];
    bit          seen;
    acc = 1'b0; acc_addr = 32'd0; seen = 1'b0;
    w_req_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      w_rsp_valid = acc;
      w_rdata = mem_word(acc_addr);
      if (w_req_valid) reqs.push_back(w_addr);
      acc = w_req_valid;
      acc_addr = w_addr;
      @(negedge clk);
      if (w_id_valid && !seen) begin
        chk("wrap_first_pc", w_id_pc, 32'hFFFF_FFFC);
        chk("wrap_first_p4", w_id_pc_plus4, 32'd0);
        seen = 1'b1;
      end
    end
    chk("wrap_bundle_seen", {31'd0, seen}, 32'd1);
    chk("wrap_req_count_ge2", {31'd0, reqs.size() >= 2}, 32'd1);
    if (reqs.size() >= 2) begin
      chk("wrap_req0", reqs[0], 32'hFFFF_FFFC);
      chk("wrap_req1", reqs[1], 32'd0);
    end
    w_req_ready = 1'b0; w_rsp_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
    logic [31:0] p4;
    logic [1:0]  imm;
  } vec_t;

  initial begin
    vec_t tab [6];
    int   n;
    int   d0;
    tab = '{
      '{32'h00, 32'h0050_0093, 32'h04, 2'b00},
      '{32'h04, 32'h0011_2223, 32'h08, 2'b01},
      '{32'h08, 32'hFE00_0EE3, 32'h0C, 2'b10},
      '{32'h0C, 32'h0080_006F, 32'h10, 2'b11},
      '{32'h10, 32'h0000_2103, 32'h14, 2'b00},
      '{32'h14, 32'h0000_80E7, 32'h18, 2'b00}
    };
    foreach (tab[i]) mem_tab[tab[i].pc] = tab[i].word;
    mem_tab[32'h100] = 32'h0FF0_0513;
    model_reset();
    delivered = 0;

    do_reset();
    wrap_test();

    // straight-line fetch, always-ready memory with 1-cycle latency
    do_reset();
    lat_min = 1; lat_max = 1;
    foreach (tab[i]) begin
      wait_bundle(8, "seq", n);
      chk("seq_pc", id_pc, tab[i].pc);
      chk("seq_instr", id_instr, tab[i].word);
      chk("seq_p4", id_pc_plus4, tab[i].p4);
      chk("seq_imm", {30'd0, id_immsrc}, {30'd0, tab[i].imm});
      if (i > 0) chk("seq_cadence", n, 2);
    end

    // stall while the addr-4 response arrives
    do_reset();
    wait_bundle(8, "st0", n);
    chk("st0_pc", id_pc, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'd0, 1'b1);
      chk("st_hold_pc", id_pc, 32'd0);
      chk("st_hold_valid", {31'd0, id_valid}, 32'd1);
      chk("st_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("st_drain_valid", {31'd0, id_valid}, 32'd1);
    chk("st_drain_pc", id_pc, 32'd4);
    chk("st_drain_instr", id_instr, 32'h0011_2223);

    // flush to 0x101 while the request to 8 is outstanding
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 1'b0, 32'd0, 1'b1);
    chk("fl_outstanding", {31'd0, pend}, 32'd1);
    chk("fl_outstanding_addr", pend_addr, 32'd8);
    cycle(1'b0, 1'b1, 32'h0000_0101, 1'b1);
    n = 0;
    while (!imem_req_valid && n < 10) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      chk("fl_no_valid", {31'd0, id_valid}, 32'd0);
      n++;
    end
    chk("fl_redirect_req", {31'd0, imem_req_valid}, 32'd1);
    chk("fl_redirect_addr", imem_addr, 32'h100);
    wait_bundle(10, "fl", n);
    chk("fl_bundle_pc", id_pc, 32'h100);
    chk("fl_bundle_instr", id_instr, 32'h0FF0_0513);

    // memory not ready for 5 cycles
    lat_min = 1; lat_max = 1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      chk("nr_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("nr_addr", imem_addr, 32'h104);
      chk("nr_no_bundle", {31'd0, id_valid}, 32'd0);
    end
    wait_bundle(8, "nr", n);
    chk("nr_bundle_pc", id_pc, 32'h104);

    // asynchronous reset while waiting with a valid bundle held
    lat_min = 3; lat_max = 3;
    cycle(1'b1, 1'b0, 32'd0, 1'b1);
    chk("ar_pre_valid", {31'd0, id_valid}, 32'd1);
    chk("ar_pre_wait", {31'd0, imem_req_valid}, 32'd0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    lat_min = 1; lat_max = 1;
    n = 0;
    while (!imem_req_valid && n < 5) begin
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      n++;
    end
    chk("ar_restart_addr", imem_addr, 32'd0);
    wait_bundle(8, "ar", n);
    chk("ar_restart_pc", id_pc, 32'd0);
    chk("ar_restart_instr", id_instr, 32'h0050_0093);

    // randomized traffic against the scoreboard
    do_reset();
    lat_min = 1; lat_max = 3;
    d0 = delivered;
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 5, $urandom, $urandom_range(0, 99) < 70);
    end
    chk("rand_progress", {31'd0, (delivered - d0) > 100}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the RISC-V32I core.
- Holds the PC, issues word reads to instruction memory over a valid/ready request channel, and captures responses.
- Presents a registered IF/ID bundle: instruction, PC, PC+4 and a pre-decoded 2-bit immediate-type select.
- The decode stage routes bits [31:7] and the immediate-type select straight into the immediate sign-extender.
- Supports decode-side stall, and branch/jump redirect (flush).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word presented while id_valid=0 (addi x0,x0,0).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  instruction memory accepts request.
- imem_addr  output  32  fetch address; always word aligned.
- imem_rsp_valid  input  1  read data valid; exactly one response per accepted request, earliest 1 cycle after acceptance.
- imem_rdata  input  32  instruction word.
- stall  input  1  decode cannot accept; hold IF/ID outputs.
- flush  input  1  redirect request.
- flush_target  input  32  new PC on flush; bits [1:0] ignored and forced to 00.
- id_valid  output  1  IF/ID bundle valid.
- id_instr  output  32  fetched instruction.
- id_pc  output  32  address of id_instr.
- id_pc_plus4  output  32  id_pc + 4.
- id_immsrc  output  2  immediate type: 00 I, 01 S, 10 B, 11 J.

Behaviour:
- Reset (asynchronous, rst_n=0) forces:
  - pc=RESET_PC and state=REQ.
  - hold buffer empty, drop flag clear.
  - id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_plus4=0, id_immsrc=00.
  - imem_req_valid=0 while rst_n=0.
- Instruction memory shares the same reset. No pre-reset response arrives after reset release.
- At most one request outstanding. States:
  - REQ: imem_req_valid=1, imem_addr=pc.
    - imem_req_ready=1 → WAIT.
    - Otherwise stay; pc and addr stable while valid is high.
  - WAIT: imem_req_valid=0.
    - On imem_rsp_valid, with the drop flag clear and the IF/ID slot free (stall=0): load IF/ID, pc<=pc+4, → REQ.
    - On imem_rsp_valid with stall=1: store word and PC in the hold buffer, → HOLD.
    - On imem_rsp_valid with the drop flag set: discard the word, clear the flag, → REQ.
  - HOLD: imem_req_valid=0. When stall=0, move the buffer into IF/ID, pc<=pc+4, → REQ.
- IF/ID register update rules:
  - stall=1: all id_* outputs hold.
  - stall=0 with a new word: id_valid=1, id_instr=word, id_pc=fetch PC, id_pc_plus4=fetch PC+4, id_immsrc decoded from word[6:0].
  - stall=0 with no new word: id_valid<=0, id_instr<=NOP_INSTR, id_immsrc<=00.
- id_immsrc decode on opcode [6:0]:
  - 0100011 → 01.
  - 1100011 → 10.
  - 1101111 → 11.
  - All others → 00 (loads, OP-IMM, JALR, and don't-care cases).
- Flush (priority over stall and over any response in the same cycle):
  - pc<=flush_target&~3; id_valid<=0; id_instr<=NOP_INSTR; hold buffer cleared.
  - In WAIT with the response not arriving this cycle, or in REQ with a request accepted this cycle: set the drop flag, → WAIT.
  - In WAIT with the response arriving this cycle: discard the word, → REQ.
  - In REQ with no acceptance, or in HOLD: → REQ.
  - The redirected request is issued the cycle after flush.
- Latency:
  - Request accepted at edge N, response at N+k (k≥1); id_valid rises at edge N+k.
  - Peak throughput is 1 instruction per 2 cycles.
- PC arithmetic is modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- Simultaneous stall and response: the response goes to the hold buffer and is never lost.
- Consecutive flushes: the last target wins, and only one drop is pending.

Test Plan:
- Reset, then memory always ready with 1-cycle responses returning 00500093, 00112223, FE000EE3, 0080006F at 0,4,8,C → id_pc sequence 0,4,8,C; id_immsrc 00,01,10,11; id_valid high every other cycle.
- Stall held 3 cycles while the response for addr 4 arrives → IF/ID holds the addr 0 bundle; after stall drops, id_pc=4 with the correct word; no request issued until the buffer drains.
- Flush to 32'h0000_0101 while a request to 8 is outstanding → addr 8 response discarded; next imem_addr=0x100; id_valid=0 until the 0x100 word arrives.
- imem_req_ready held low 5 cycles → imem_req_valid stays 1 and imem_addr stable; no pc advance.
- Start RESET_PC=32'hFFFF_FFFC → second request address 0x0000_0000; id_pc_plus4 for the first bundle is 0.
- Assert rst_n=0 in WAIT with id_valid=1 → outputs return to reset values immediately; fetch restarts at RESET_PC after release.
